pll_reset_sequencer: RTL and testbench

PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

---
 rtl/pll_reset_sequencer.sv | 141 ++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pll_reset_sequencer
// Purpose  : Pulses the PLL reset, qualifies lock and releases the downstream
//            reset; PLL_SEQ_TIMEOUT_EN adds a WAIT_LOCK retry timeout.
// Revision : 1.0
// ============================================================================
module pll_reset_sequencer #(
    parameter int RST_CYCLES          = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int CNT_W               = 17
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       restart_req,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic [7:0] relock_count,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        PLL_RESET = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam int C_MAX_RS    = (RST_CYCLES > LOCK_STABLE_CYCLES) ? RST_CYCLES : LOCK_STABLE_CYCLES;
    localparam int C_MAX_COUNT = (C_MAX_RS > LOCK_TIMEOUT_CYCLES) ? C_MAX_RS : LOCK_TIMEOUT_CYCLES;

    localparam logic [CNT_W-1:0] C_RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
`ifdef PLL_SEQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] C_TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
`endif

    if (CNT_W < $clog2(C_MAX_COUNT + 1)) begin : g_cnt_w_check
        $error("pll_reset_sequencer: CNT_W too narrow for the largest cycle count");
    end

    logic [1:0]       r_sync;
    logic             w_lock_s;
    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             w_cnt_run;
    logic             w_lock_lost;
    logic             r_pll_rst;
    logic             r_sys_rst_n;
    logic [7:0]       r_relock;

    // pll_locked is asynchronous to refclk; only the second flop is trusted.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], pll_locked};
        end
    end

    assign w_lock_s = r_sync[1];

    always_comb begin
        w_next      = r_state;
        w_cnt_run   = 1'b0;
        w_lock_lost = 1'b0;
        case (r_state)
            PLL_RESET: begin
                w_cnt_run = 1'b1;
                if (r_cnt == C_RST_LAST) begin
                    w_next = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                if (w_lock_s) begin
                    w_next = STABLE;
                end
`ifdef PLL_SEQ_TIMEOUT_EN
                else begin
                    w_cnt_run = 1'b1;
                    if (r_cnt == C_TIMEOUT_LAST) begin
                        w_next = PLL_RESET;
                    end
                end
`endif
            end
            STABLE: begin
                if (!w_lock_s) begin
                    w_next = WAIT_LOCK;
                end else begin
                    w_cnt_run = 1'b1;
                    if (r_cnt == C_STABLE_LAST) begin
                        w_next = RUN;
                    end
                end
            end
            RUN: begin
                // Lock loss takes priority so a coincident restart still counts.
                if (!w_lock_s) begin
                    w_next      = PLL_RESET;
                    w_lock_lost = 1'b1;
                end else if (restart_req) begin
                    w_next = PLL_RESET;
                end
            end
            default: w_next = PLL_RESET;
        endcase
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= PLL_RESET;
            r_cnt       <= '0;
            r_pll_rst   <= 1'b1;
            r_sys_rst_n <= 1'b0;
            r_relock    <= 8'd0;
        end else begin
            r_state     <= w_next;
            r_pll_rst   <= (w_next == PLL_RESET);
            r_sys_rst_n <= (w_next == RUN);
            if ((w_next != r_state) || !w_cnt_run) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_lock_lost && (r_relock != 8'hFF)) begin
                r_relock <= r_relock + 8'd1;
            end
        end
    end

    assign pll_rst      = r_pll_rst;
    assign sys_rst_n    = r_sys_rst_n;
    assign relock_count = r_relock;
    assign state        = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pll_reset_sequencer
// Purpose  : Self-checking bench for pll_reset_sequencer (small parameters).
// Revision : 1.0
// ============================================================================
module tb_pll_reset_sequencer;

    localparam int RST_C    = 4;
    localparam int STABLE_C = 8;
    localparam int TIMEOUT_C = 32;
`ifdef PLL_SEQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       refclk = 1'b0;
    logic       rst_n = 1'b1;
    logic       pll_locked = 1'b0;
    logic       restart_req = 1'b0;
    logic       pll_rst;
    logic       sys_rst_n;
    logic [7:0] relock_count;
    logic [1:0] state;

    pll_reset_sequencer #(
        .RST_CYCLES         (RST_C),
        .LOCK_STABLE_CYCLES (STABLE_C),
        .LOCK_TIMEOUT_CYCLES(TIMEOUT_C),
        .CNT_W              (6)
    ) dut (
        .refclk      (refclk),
        .rst_n       (rst_n),
        .pll_locked  (pll_locked),
        .restart_req (restart_req),
        .pll_rst     (pll_rst),
        .sys_rst_n   (sys_rst_n),
        .relock_count(relock_count),
        .state       (state)
    );

    always #5 refclk = ~refclk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: phase number, cycles spent in it, lock-loss tally,
    // and the raw pll_locked samples that are still in flight to lock_s.
    int m_phase;
    int m_since;
    int m_relock;
    bit m_hist[$];

    typedef struct {
        int lock_rise;
        int glitch;
        int run_edge;
    } vec_t;
    vec_t vecs[9];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase  = 0;
        m_since  = 0;
        m_relock = 0;
        m_hist   = '{1'b0, 1'b0};
    endtask

    task automatic model_edge();
        bit ls;
        int nxt;
        ls = m_hist.pop_front();
        m_hist.push_back(pll_locked);
        nxt = m_phase;
        case (m_phase)
            0: if (m_since + 1 >= RST_C) nxt = 1;
            1: begin
                if (ls) nxt = 2;
                else if (TO_EN && (m_since + 1 >= TIMEOUT_C)) nxt = 0;
            end
            2: begin
                if (!ls) nxt = 1;
                else if (m_since + 1 >= STABLE_C) nxt = 3;
            end
            default: begin
                if (!ls) begin
                    nxt = 0;
                    m_relock = (m_relock < 255) ? m_relock + 1 : 255;
                end else if (restart_req) begin
                    nxt = 0;
                end
            end
        endcase
        if (nxt != m_phase) begin
            m_phase = nxt;
            m_since = 0;
        end else begin
            m_since++;
        end
    endtask

    task automatic tick();
        @(posedge refclk);
        if (rst_n) model_edge();
        #1;
        chk("model_state", int'(state), m_phase);
        chk("model_pll_rst", int'(pll_rst), int'(m_phase == 0));
        chk("model_sys_rst_n", int'(sys_rst_n), int'(m_phase == 3));
        chk("model_relock", int'(relock_count), m_relock);
    endtask

    task automatic apply_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        chk({tag, "_state"}, int'(state), 0);
        chk({tag, "_pll_rst"}, int'(pll_rst), 1);
        chk({tag, "_sys_rst_n"}, int'(sys_rst_n), 0);
        chk({tag, "_relock"}, int'(relock_count), 0);
        model_reset();
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_phase(input int target, input int budget, input string name);
        int n;
        n = 0;
        while ((m_phase != target) && (n < budget)) begin
            tick();
            n++;
        end
        chk(name, int'(state), target);
    endtask

    initial begin
        vecs[0] = '{10, -1, 21};
        vecs[1] = '{0, -1, 13};
        vecs[2] = '{2, -1, 13};
        vecs[3] = '{3, -1, 14};
        vecs[4] = '{5, -1, 16};
        vecs[5] = '{10, 16, 28};
        vecs[6] = '{10, 11, 23};
        vecs[7] = '{20, 25, 37};
        vecs[8] = '{20, 28, 40};

        model_reset();

        // Power-up and stability-glitch vectors: expected release edge per record.
        for (int v = 0; v < 9; v++) begin
            pll_locked = 1'b0;
            apply_reset("por");
            for (int k = 1; k <= vecs[v].run_edge + 2; k++) begin
                pll_locked = ((k - 1) >= vecs[v].lock_rise) && ((k - 1) != vecs[v].glitch);
                tick();
                chk("vec_sys_rst_n", int'(sys_rst_n), int'(k >= vecs[v].run_edge));
                chk("vec_pll_rst", int'(pll_rst), int'(k < RST_C));
            end
            chk("vec_relock", int'(relock_count), 0);
        end

        // Lock loss in RUN: downstream reset on the 3rd edge, then a 4-cycle pulse.
        pll_locked = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk("loss_sys_rst_n", int'(sys_rst_n), int'(k < 3));
            chk("loss_pll_rst", int'(pll_rst), int'((k >= 3) && (k <= 6)));
        end
        chk("loss_relock", int'(relock_count), 1);

        for (int i = 2; i <= 300; i++) begin
            pll_locked = 1'b1;
            wait_phase(3, 60, "sat_run");
            pll_locked = 1'b0;
            wait_phase(0, 10, "sat_loss");
            if (i == 254) chk("relock_254", int'(relock_count), 254);
            if (i == 256) chk("relock_256", int'(relock_count), 255);
        end
        chk("relock_sat", int'(relock_count), 255);

        // restart_req handling.
        apply_reset("rs");
        pll_locked = 1'b0;
        wait_phase(1, 20, "rs_wait");
        restart_req = 1'b1;
        tick();
        restart_req = 1'b0;
        chk("restart_wait_state", int'(state), 1);
        pll_locked = 1'b1;
        wait_phase(3, 60, "rs_run");
        restart_req = 1'b1;
        tick();
        restart_req = 1'b0;
        chk("restart_run_state", int'(state), 0);
        chk("restart_run_relock", int'(relock_count), 0);
        wait_phase(3, 60, "rs_run2");
        pll_locked = 1'b0;
        tick();
        tick();
        restart_req = 1'b1;
        tick();
        restart_req = 1'b0;
        chk("restart_loss_state", int'(state), 0);
        chk("restart_loss_relock", int'(relock_count), 1);
        for (int i = 0; i < 2; i++) begin
            pll_locked = 1'b1;
            wait_phase(3, 60, "rs_relock_run");
            pll_locked = 1'b0;
            wait_phase(0, 10, "rs_relock_loss");
        end
        pll_locked = 1'b1;
        wait_phase(3, 60, "rs_run3");
        chk("midrun_relock_pre", int'(relock_count), 3);
        apply_reset("midrun");

        // Lock never arrives.
        apply_reset("to");
        pll_locked = 1'b0;
        for (int k = 1; k <= 150; k++) begin
            tick();
            chk("to_pll_rst", int'(pll_rst), TO_EN ? int'((k % (RST_C + TIMEOUT_C)) < RST_C) : int'(k < RST_C));
        end
        chk("to_state", int'(state), 1);

        // Random lock activity and restarts against the model.
        apply_reset("rnd");
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) < 4) pll_locked = ~pll_locked;
            restart_req = ($urandom_range(0, 39) == 0);
            tick();
        end
        restart_req = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
